// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: WB stage vs buffered long-latency results, with a RAW busy scoreboard.
// Zero-cycle grant to the write port; lu_ready_o drops when the FIFO is full. WB_BYPASS_EN clears busy in the commit cycle.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int REG_NUM    = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pipe_we_i,
    input  logic [ADDR_W-1:0] pipe_waddr_i,
    input  logic [DATA_W-1:0] pipe_wdata_i,
    input  logic              lu_valid_i,
    output logic              lu_ready_o,
    input  logic [ADDR_W-1:0] lu_waddr_i,
    input  logic [DATA_W-1:0] lu_wdata_i,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    output logic              stall_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [PTR_W:0]   DEPTH_C = FIFO_DEPTH[PTR_W:0];
    localparam logic [CNT_W-1:0] MAX_C   = MAX_WAIT[CNT_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;
    logic [CNT_W-1:0]  r_cnt;
    state_t            r_state;
    logic              r_stall;
    logic [REG_NUM-1:0] r_busy;

    logic              w_push;
    logic              w_fifo_ne;
    logic              w_pipe_gnt;
    logic              w_head_gnt;
    logic [ADDR_W-1:0] w_head_addr;
    logic [PTR_W:0]    w_count_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_rs1_clr;
    logic              w_rs2_clr;

    assign w_fifo_ne   = (r_count != '0);
    assign lu_ready_o  = (r_count < DEPTH_C);
    assign w_push      = rst_i && lu_valid_i && lu_ready_o;
    assign w_head_addr = r_fifo_addr[r_rptr];

    // Held WB inputs are ignored during the forced stall, so the head always wins then.
    assign w_pipe_gnt  = rst_i && pipe_we_i && (pipe_waddr_i != '0) && !r_stall;
    assign w_head_gnt  = rst_i && w_fifo_ne && !w_pipe_gnt;

    assign we_o    = w_pipe_gnt || w_head_gnt;
    assign waddr_o = w_head_gnt ? w_head_addr : pipe_waddr_i;
    assign wdata_o = w_head_gnt ? r_fifo_data[r_rptr] : pipe_wdata_i;
    assign stall_o = r_stall;

    assign w_count_nxt = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_head_gnt};
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

`ifdef WB_BYPASS_EN
    assign w_rs1_clr = w_head_gnt && (w_head_addr == rs1_addr_i);
    assign w_rs2_clr = w_head_gnt && (w_head_addr == rs2_addr_i);
`else
    assign w_rs1_clr = 1'b0;
    assign w_rs2_clr = 1'b0;
`endif

    assign rs1_busy_o = r_busy[rs1_addr_i] && (rs1_addr_i != '0) && !w_rs1_clr;
    assign rs2_busy_o = r_busy[rs2_addr_i] && (rs2_addr_i != '0) && !w_rs2_clr;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= lu_waddr_i;
            r_fifo_data[r_wptr] <= lu_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_stall <= 1'b0;
            r_busy  <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_head_gnt)
                r_rptr <= r_rptr + PTR_W'(1);
            r_count <= w_count_nxt;

            // Clear before set so a same-cycle issue to the committing register stays busy.
            if (w_head_gnt)
                r_busy[w_head_addr] <= 1'b0;
            if (issue_i && (issue_rd_i != '0))
                r_busy[issue_rd_i] <= 1'b1;

            case (r_state)
                S_FORCE: begin
                    r_stall <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= (w_count_nxt != '0) ? S_WAIT : S_IDLE;
                end
                default: begin
                    if (w_head_gnt) begin
                        r_cnt   <= '0;
                        r_state <= (w_count_nxt != '0) ? S_WAIT : S_IDLE;
                    end else if (w_fifo_ne) begin
                        if (w_cnt_inc == MAX_C) begin
                            r_cnt   <= '0;
                            r_state <= S_FORCE;
                            r_stall <= 1'b1;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with default parameters (FIFO_DEPTH=2, MAX_WAIT=4).
module tb_regfile_wb_arbiter;
`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pipe_we_i;
    logic [4:0]  pipe_waddr_i;
    logic [31:0] pipe_wdata_i;
    logic        lu_valid_i;
    logic        lu_ready_o;
    logic [4:0]  lu_waddr_i;
    logic [31:0] lu_wdata_i;
    logic        issue_i;
    logic [4:0]  issue_rd_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic        stall_o;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb_pending;

    regfile_wb_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
        .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o),
        .lu_waddr_i(lu_waddr_i), .lu_wdata_i(lu_wdata_i),
        .issue_i(issue_i), .issue_rd_i(issue_rd_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .stall_o(stall_o), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        check({tag, ".we"}, we_o, we);
        if (we) begin
            check({tag, ".addr"}, waddr_o, a);
            check({tag, ".data"}, wdata_o, d);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        pipe_we_i    = 1'b0;
        pipe_waddr_i = '0;
        pipe_wdata_i = '0;
        lu_valid_i   = 1'b0;
        lu_waddr_i   = '0;
        lu_wdata_i   = '0;
        issue_i      = 1'b0;
        issue_rd_i   = '0;
    endtask

    task automatic issue(input logic [4:0] rd);
        assert (!sb_pending[rd]) else $error("FAIL issue_to_busy rd=%0d", rd);
        issue_i    = 1'b1;
        issue_rd_i = rd;
        sb_pending[rd] = 1'b1;
    endtask

    task automatic lu_push(input logic [4:0] a, input logic [31:0] d);
        lu_valid_i = 1'b1;
        lu_waddr_i = a;
        lu_wdata_i = d;
        sb_pending[a] = 1'b0;
    endtask

    logic [4:0]  t4_exp_a [8] = '{5'd10, 5'd10, 5'd10, 5'd10, 5'd11, 5'd12, 5'd13, 5'd0};
    logic [31:0] t4_exp_d [8] = '{32'hB0, 32'hB0, 32'hB0, 32'hB0, 32'h11, 32'h12, 32'h13, 32'h0};
    logic        t4_exp_r [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int k;
        sb_pending = '0;
        idle();
        rs1_addr_i = '0;
        rs2_addr_i = '0;

        // Reset with a pending WB write: write enable must be held low.
        rst_i = 1'b0;
        pipe_we_i = 1'b1; pipe_waddr_i = 5'd3; pipe_wdata_i = 32'h1;
        tick(); #1;
        check("rst.we_forced", we_o, 1'b0);
        tick();
        rst_i = 1'b1;
        idle();
        #1;
        check("idle.we", we_o, 1'b0);
        check("idle.ready", lu_ready_o, 1'b1);
        check("idle.stall", stall_o, 1'b0);
        for (int r = 0; r < 32; r++) begin
            rs1_addr_i = 5'(r);
            rs2_addr_i = 5'(31 - r);
            #1;
            check("idle.rs1_busy", rs1_busy_o, 1'b0);
            check("idle.rs2_busy", rs2_busy_o, 1'b0);
        end

        // Long-latency result to x5, scoreboard tracking.
        tick();
        issue(5'd5);
        rs1_addr_i = 5'd5; rs2_addr_i = 5'd5;
        #1;
        check("t2.busy_same_cycle", rs1_busy_o, 1'b0);
        tick(); idle(); #1;
        check("t2.rs1_busy", rs1_busy_o, 1'b1);
        check("t2.rs2_busy", rs2_busy_o, 1'b1);
        tick(); #1;
        tick();
        lu_push(5'd5, 32'hA5A5A5A5);
        #1;
        chk_wr("t2.push_cycle", 1'b0, 5'd0, 32'h0);
        check("t2.busy_push", rs1_busy_o, 1'b1);
        tick(); idle(); #1;
        chk_wr("t2.commit", 1'b1, 5'd5, 32'hA5A5A5A5);
        check("t2.busy_commit", rs1_busy_o, !BYP);
        tick(); #1;
        chk_wr("t2.after", 1'b0, 5'd0, 32'h0);
        check("t2.busy_after", rs1_busy_o, 1'b0);

        // Continuous WB stream starves the FIFO head until the forced stall.
        k = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            idle();
            pipe_we_i = 1'b1; pipe_waddr_i = 5'(k); pipe_wdata_i = 32'h100 + k;
            if (i == 0) lu_push(5'd7, 32'h77);
            #1;
            check("t3.stall", stall_o, (i == 5));
            if (i == 5) chk_wr("t3.forced", 1'b1, 5'd7, 32'h77);
            else        chk_wr("t3.pipe", 1'b1, 5'(k), 32'h100 + k);
            if (i != 5) k++;
        end
        tick(); idle(); #1;
        check("t3.end_stall", stall_o, 1'b0);
        chk_wr("t3.end", 1'b0, 5'd0, 32'h0);

        // FIFO fill, backpressure and in-order drain.
        for (int c = 0; c < 8; c++) begin
            tick();
            idle();
            if (c < 4) begin pipe_we_i = 1'b1; pipe_waddr_i = 5'd10; pipe_wdata_i = 32'hB0; end
            if (c == 0) lu_push(5'd11, 32'h11);
            else if (c == 1) lu_push(5'd12, 32'h12);
            else if (c < 6) lu_push(5'd13, 32'h13);
            #1;
            check("t4.ready", lu_ready_o, t4_exp_r[c]);
            check("t4.stall", stall_o, 1'b0);
            chk_wr("t4.wr", (c < 7), t4_exp_a[c], t4_exp_d[c]);
        end

        // Write to x0 is not a request; FIFO head takes the port.
        tick(); idle();
        pipe_we_i = 1'b1; pipe_waddr_i = 5'd0; pipe_wdata_i = 32'hDEAD;
        lu_push(5'd9, 32'h99);
        #1;
        chk_wr("t5.x0_empty", 1'b0, 5'd0, 32'h0);
        tick(); lu_valid_i = 1'b0; #1;
        chk_wr("t5.head", 1'b1, 5'd9, 32'h99);
        tick(); #1;
        chk_wr("t5.x0_only", 1'b0, 5'd0, 32'h0);

        // Same-cycle issue and commit to x4, then reset with a non-empty FIFO.
        tick(); idle();
        lu_push(5'd4, 32'h44);
        rs1_addr_i = 5'd4; rs2_addr_i = 5'd8;
        #1;
        chk_wr("t6.push", 1'b0, 5'd0, 32'h0);
        tick(); idle();
        issue(5'd4);
        #1;
        chk_wr("t6.commit4", 1'b1, 5'd4, 32'h44);
        check("t6.busy_before", rs1_busy_o, 1'b0);
        tick(); idle(); #1;
        check("t6.set_wins", rs1_busy_o, 1'b1);
        tick(); idle();
        pipe_we_i = 1'b1; pipe_waddr_i = 5'd10; pipe_wdata_i = 32'hC0;
        lu_push(5'd8, 32'h88);
        #1;
        chk_wr("t6.pipe", 1'b1, 5'd10, 32'hC0);
        tick();
        rst_i = 1'b0;
        lu_valid_i = 1'b0;
        #1;
        check("t6.rst_we", we_o, 1'b0);
        tick();
        rst_i = 1'b1;
        idle();
        sb_pending = '0;
        #1;
        chk_wr("t6.dropped", 1'b0, 5'd0, 32'h0);
        check("t6.ready", lu_ready_o, 1'b1);
        check("t6.stall", stall_o, 1'b0);
        check("t6.busy4", rs1_busy_o, 1'b0);
        tick(); #1;
        chk_wr("t6.dropped2", 1'b0, 5'd0, 32'h0);
        for (int r = 1; r < 32; r++) begin
            rs1_addr_i = 5'(r);
            #1;
            check("t6.busy_clear", rs1_busy_o, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - the in-order pipeline WB stage;
  - the long-latency unit (mul/div/load-miss), whose results arrive out of band.
- Buffers long-latency results in a small FIFO and guarantees they are not starved by forcing a one-cycle pipeline stall.
- Keeps a per-register busy scoreboard so ID can stall on RAW hazards against outstanding long-latency destinations.
- Sits between WB and the regfile write port; busy outputs feed ID hazard logic.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- REG_NUM, 32, number of architectural registers.
- FIFO_DEPTH, 2, long-latency result buffer entries (power of 2, >=2).
- MAX_WAIT, 4, consecutive blocked cycles of FIFO head before a forced stall (>=1).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, synchronous, active-low (0 = reset).
- pipe_we_i  in  1  WB stage write request.
- pipe_waddr_i  in  ADDR_W  WB destination.
- pipe_wdata_i  in  DATA_W  WB data.
- lu_valid_i  in  1  long-unit result valid.
- lu_ready_o  out  1  FIFO can accept.
- lu_waddr_i  in  ADDR_W  long-unit destination.
- lu_wdata_i  in  DATA_W  long-unit data.
- issue_i  in  1  ID issues a long-latency op this cycle.
- issue_rd_i  in  ADDR_W  its destination.
- rs1_addr_i  in  ADDR_W  ID source 1.
- rs2_addr_i  in  ADDR_W  ID source 2.
- rs1_busy_o  out  1  rs1 pending.
- rs2_busy_o  out  1  rs2 pending.
- stall_o  out  1  registered; freezes the pipeline for one cycle.
- we_o  out  1  regfile write enable.
- waddr_o  out  ADDR_W  regfile write address.
- wdata_o  out  DATA_W  regfile write data.

Behaviour:

Reset (rst_i=0 at clock edge):
- FIFO emptied (contents dropped, never written), busy bits all 0, wait counter 0, FSM IDLE, stall_o=0.
- While rst_i=0, we_o is forced to 0.

FIFO:
- Push when lu_valid_i && lu_ready_o.
- lu_ready_o = (count < FIFO_DEPTH), from registered count only; a same-cycle pop does not raise ready.
- Pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle leave count unchanged.

Grant (combinational, per cycle):
- Pipeline request = pipe_we_i && pipe_waddr_i != 0. A write to x0 is not a request.
- If stall_o=1 and FIFO non-empty: FIFO head wins.
- Else if pipeline request: pipeline wins.
- Else if FIFO non-empty: FIFO head wins.
- Else: we_o=0.
- Pop the FIFO exactly when the head is granted.
- While stall_o=1, the pipeline holds its WB inputs stable and re-presents them next cycle; the arbiter ignores them that cycle.

Latency:
- 0 cycles from a grant to the regfile write inputs.
- Minimum 1 cycle from lu push to write, since the FIFO is registered.

FSM:
- IDLE:
  - FIFO empty, or head granted this cycle with nothing behind it.
  - Goes to WAIT when the FIFO is non-empty and the head is not granted.
- WAIT:
  - Counter increments each blocked cycle and resets to 0 on a head grant.
  - When counter reaches MAX_WAIT: go to FORCE, set stall_o=1 next cycle.
- FORCE:
  - stall_o=1 for exactly one cycle and the head commits.
  - Then go to WAIT (counter=0) if the FIFO is still non-empty, else IDLE.
- A back-to-back pipeline stream delays a long result by at most MAX_WAIT+1 cycles.

Scoreboard:
- issue_i && issue_rd_i != 0 sets busy[issue_rd_i].
- A FIFO head commit clears busy[waddr].
- Same-cycle set and clear of the same register: set wins.
- ID never issues to a register already busy; the bench checks this with an assertion.
- rsN_busy_o = busy[rsN_addr_i] && rsN_addr_i != 0.

Optional Feature:
- WB_BYPASS_EN defined:
  - rsN_busy_o also deasserts in the cycle the FIFO head commits to rsN.
  - ID then reads that value through the regfile write-through path.
- Undefined: busy clears the following cycle (one extra stall cycle).

Test Plan:
- Reset then idle, lu_valid_i=0 -> we_o=0, lu_ready_o=1, stall_o=0, all busy=0.
- issue rd=5; 3 cycles later lu result (5,0xA5A5A5A5), pipe idle -> we_o=1 addr 5 data 0xA5A5A5A5 one cycle after push; rs1=5 busy until commit (cleared same cycle with WB_BYPASS_EN, next cycle without).
- Pipe writes every cycle to x1..; lu pushes (7,0x77), MAX_WAIT=4 -> stall_o=1 exactly once, 5 cycles after push; write 7/0x77 that cycle; held pipe write lands the next cycle.
- lu pushes 3 results, pipe busy, FIFO_DEPTH=2 -> lu_ready_o=0 after 2 pushes; entries commit in FIFO order; third accepted only after a pop.
- pipe_we_i=1 addr 0 while FIFO has (9,0x99) -> FIFO head granted; no write to x0.
- Issue rd=4 and a commit to 4 in the same cycle -> busy[4]=1; FIFO non-empty, rst_i=0 for one cycle -> FIFO dropped, no write afterwards, busy all 0.
